// File: rtl/vga_pkg.sv
// Shared VGA timing package.
// Holds the default 640x480@60 Hz timing (100 MHz clock, 25 MHz pixel rate),
// the derived line/frame totals and the sync window bounds. The colour stage
// and the top both read these constants.
package vga_pkg;

  localparam int COORD_W_DEF  = 10;
  typedef logic [COORD_W_DEF-1:0] coord_t;

  localparam int   CLK_DIV_DEF  = 4;
  localparam int   H_ACTIVE_DEF = 640;
  localparam int   H_FP_DEF     = 16;
  localparam int   H_SYNC_DEF   = 96;
  localparam int   H_BP_DEF     = 48;
  localparam int   V_ACTIVE_DEF = 480;
  localparam int   V_FP_DEF     = 10;
  localparam int   V_SYNC_DEF   = 2;
  localparam int   V_BP_DEF     = 33;
  localparam logic SYNC_POL_DEF = 1'b0;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Inclusive sync windows in counter units (656..751 and 490..491).
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider.
// Counts 0..CLK_DIV-1 on every clock and flags the last clock of each period.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   adv_o   high on the last clock of each CLK_DIV-clock period
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic adv_o
);

  // At least one bit so CLK_DIV==1 still elaborates; the counter then sits
  // at 0 and adv_o is permanently high.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign adv_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (adv_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator.
// Produces sync, pixel enable, active-video flag and pixel coordinates for
// the downstream colour stage. Every output is a registered decode of the
// internal counters, so all outputs share one clock of latency.
// Ports:
//   clk_i           system clock
//   reset_ni        asynchronous active-low reset
//   pix_tick_o      one-clock pulse on the last clock of each pixel period
//   hsync_o         horizontal sync, active level SYNC_POL
//   vsync_o         vertical sync, active level SYNC_POL
//   video_on_o      inside the visible area
//   x_o, y_o        pixel column / line counters
//   line_start_o    pix_tick where x==0
//   frame_start_o   pix_tick where x==0 and y==0
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = CLK_DIV_DEF,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  parameter int   COORD_W  = COORD_W_DEF
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  output logic               pix_tick_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               video_on_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               line_start_o,
  output logic               frame_start_o
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic adv;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk_i  (clk_i),
    .rst_ni (reset_ni),
    .adv_o  (adv)
  );

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

  // v wraps on the same edge as the h wrap at the last line.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (adv) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) v_cnt_d = '0;
        else                   v_cnt_d = v_cnt_q + COORD_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic               pix_tick_q, pix_tick_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  always_comb begin
    pix_tick_d    = adv;
    x_d           = h_cnt_q;
    y_d           = v_cnt_q;
    video_on_d    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    if ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) hsync_d = SYNC_POL;
    if ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) vsync_d = SYNC_POL;
    line_start_d  = adv && (h_cnt_q == '0);
    frame_start_d = adv && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick_o    = pix_tick_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one instance at the default 640x480 timing and one
// small-raster instance (CLK_DIV=1, active-high sync) that can run many
// complete frames in a short time.
module tb_vga_sync_gen;

  localparam int A_D = 4, A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam logic A_POL = 1'b0;

  localparam int S_D = 1, S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam logic S_POL = 1'b1;

  logic clk = 1'b0;
  logic rst_a, rst_s;

  logic       a_pt, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       s_pt, s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int failures = 0;
  longint ka = 0, ks = 0;   // clock edges since reset release, per instance
  bit chk_en = 1'b0;
  int s_fs_cnt = 0, s_vs_cnt = 0, s_ls_cnt = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk_i(clk), .reset_ni(rst_a), .pix_tick_o(a_pt), .hsync_o(a_hs),
    .vsync_o(a_vs), .video_on_o(a_von), .x_o(a_x), .y_o(a_y),
    .line_start_o(a_ls), .frame_start_o(a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(S_D), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(S_POL), .COORD_W(10)
  ) dut_s (
    .clk_i(clk), .reset_ni(rst_s), .pix_tick_o(s_pt), .hsync_o(s_hs),
    .vsync_o(s_vs), .video_on_o(s_von), .x_o(s_x), .y_o(s_y),
    .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  always @(posedge clk) begin
    if (rst_a) ka++;
    if (rst_s) ks++;
  end

  // Expected outputs after k edges since release. The outputs after edge k
  // describe the raster position reached after k-1 clocks: pixel number
  // (k-1)/D since release, decomposed into column and line.
  // Packed as {pix_tick, hsync, vsync, video_on, line_start, frame_start, x, y}.
  function automatic logic [25:0] model(input int d, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input logic pol, input longint k);
    longint m, p;
    int ht, vt, h, v;
    logic pt, hsv, vsv, von, ls, fs;
    if (k == 0) return {1'b0, ~pol, ~pol, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    m   = k - 1;
    p   = m / d;
    h   = int'(p % ht);
    v   = int'((p / ht) % vt);
    pt  = ((m % d) == d - 1);
    von = (h < ha) && (v < va);
    hsv = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    vsv = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    ls  = pt && (h == 0);
    fs  = ls && (v == 0);
    return {pt, hsv, vsv, von, ls, fs, 10'(h), 10'(v)};
  endfunction

  task automatic check_vec(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got pt/hs/vs/von/ls/fs=%b%b%b%b%b%b x=%0d y=%0d want %b%b%b%b%b%b x=%0d y=%0d",
               name, $time, act[25], act[24], act[23], act[22], act[21], act[20],
               act[19:10], act[9:0], exp[25], exp[24], exp[23], exp[22], exp[21],
               exp[20], exp[19:10], exp[9:0]);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("A_cycle", {a_pt, a_hs, a_vs, a_von, a_ls, a_fs, a_x, a_y},
                model(A_D, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, ka));
      check_vec("S_cycle", {s_pt, s_hs, s_vs, s_von, s_ls, s_fs, s_x, s_y},
                model(S_D, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_POL, ks));
      if (ks >= 1 && ks <= 240) begin
        if (s_fs) s_fs_cnt++;
        if (s_ls) s_ls_cnt++;
        if (s_vs == S_POL) s_vs_cnt++;
      end
    end
  end

  task automatic goto_a(input longint n);
    int guard = 0;
    while (ka < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (ka != n) begin
      failures++;
      $display("FAIL goto_a timeout got %0d want %0d", ka, n);
    end
  endtask

  task automatic goto_s(input longint n);
    int guard = 0;
    while (ks < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (ks != n) begin
      failures++;
      $display("FAIL goto_s timeout got %0d want %0d", ks, n);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_s = 1'b1;
    #2;
    rst_a = 1'b0;
    rst_s = 1'b0;
    chk_en = 1'b1;
    #30;
    lit("rst_hsync", int'(a_hs), 1);
    lit("rst_vsync", int'(a_vs), 1);
    lit("rst_video_on", int'(a_von), 0);
    lit("rst_x", int'(a_x), 0);
    lit("rst_y", int'(a_y), 0);
    lit("rst_pix_tick", int'(a_pt), 0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_s = 1'b1;

    goto_a(1);
    lit("e1_video_on", int'(a_von), 1);
    lit("e1_x", int'(a_x), 0);
    lit("e1_pix_tick", int'(a_pt), 0);
    goto_a(3);  lit("e3_pix_tick", int'(a_pt), 0);
    goto_a(4);  lit("e4_pix_tick", int'(a_pt), 1);
    goto_a(5);  lit("e5_pix_tick", int'(a_pt), 0);
    lit("e5_x", int'(a_x), 1);

    goto_s(120);
    lit("s_last_x", int'(s_x), 14);
    lit("s_last_y", int'(s_y), 7);
    goto_s(121);
    lit("s_wrap_x", int'(s_x), 0);
    lit("s_wrap_y", int'(s_y), 0);
    lit("s_wrap_frame_start", int'(s_fs), 1);

    goto_a(2560); lit("a_von_x639", int'(a_von), 1); lit("a_x639", int'(a_x), 639);
    goto_a(2561); lit("a_von_x640", int'(a_von), 0); lit("a_x640", int'(a_x), 640);
    goto_a(2624); lit("a_hs_x655", int'(a_hs), 1);
    goto_a(2625); lit("a_hs_x656", int'(a_hs), 0); lit("a_x656", int'(a_x), 656);
    goto_a(3008); lit("a_hs_x751", int'(a_hs), 0); lit("a_x751", int'(a_x), 751);
    goto_a(3009); lit("a_hs_x752", int'(a_hs), 1);
    goto_a(3200); lit("a_x799", int'(a_x), 799); lit("a_y_l0", int'(a_y), 0);
    lit("a_pt_x799", int'(a_pt), 1);
    goto_a(3201); lit("a_wrap_x", int'(a_x), 0); lit("a_wrap_y", int'(a_y), 1);
    goto_a(3204); lit("a_line_start", int'(a_ls), 1); lit("a_ls_no_fs", int'(a_fs), 0);
    goto_a(3205); lit("a_line_start_end", int'(a_ls), 0);

    // Mid-frame reset between clock edges.
    goto_a(33202);
    lit("a_mid_x", int'(a_x), 300);
    lit("a_mid_y", int'(a_y), 10);
    #1;
    rst_a = 1'b0;
    ka = 0;
    #1;
    lit("mid_rst_x", int'(a_x), 0);
    lit("mid_rst_y", int'(a_y), 0);
    lit("mid_rst_video_on", int'(a_von), 0);
    lit("mid_rst_hsync", int'(a_hs), 1);
    lit("mid_rst_vsync", int'(a_vs), 1);
    lit("mid_rst_pix_tick", int'(a_pt), 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    goto_a(1);
    lit("re_e1_video_on", int'(a_von), 1);
    lit("re_e1_x", int'(a_x), 0);
    goto_a(4); lit("re_e4_pix_tick", int'(a_pt), 1);
    lit("re_e4_frame_start", int'(a_fs), 1);
    goto_a(3300);

    lit("s_frame_starts_2f", s_fs_cnt, 2);
    lit("s_line_starts_2f", s_ls_cnt, 16);
    lit("s_vsync_active_clks_2f", s_vs_cnt, 60);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz board clock, using a divide-by-4 pixel enable (25 MHz).
- Sits directly upstream of the colour/pixel stage in the basys_vga top. It supplies Hsync/Vsync, the pixel enable, active-video flag and pixel coordinates that the colour logic consumes to drive vgaRed/vgaGreen/vgaBlue.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- COORD_W, 10, coordinate width; H_TOTAL and V_TOTAL must be <= 2**COORD_W

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- pix_tick  out  1  one-clk pulse, last clk of each pixel period
- hsync  out  1  horizontal sync, polarity set by SYNC_POL
- vsync  out  1  vertical sync, polarity set by SYNC_POL
- video_on  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- x  out  COORD_W  horizontal pixel counter, 0..H_TOTAL-1
- y  out  COORD_W  vertical line counter, 0..V_TOTAL-1
- line_start  out  1  pulse on the pix_tick where x==0
- frame_start  out  1  pulse on the pix_tick where x==0 and y==0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Derived totals: H_TOTAL = sum of H terms = 800; V_TOTAL = sum of V terms = 525.
- Internal state:
  - div_cnt counts 0..CLK_DIV-1 every clk and wraps to 0.
  - adv = (div_cnt == CLK_DIV-1).
  - On a clk edge with adv: h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt wraps from V_TOTAL-1 to 0 on the same edge h_cnt wraps.
- Output stage: all outputs are registered decodes of the internal state, one clk latency. All outputs are mutually aligned.
  - pix_tick <= adv
  - x <= h_cnt; y <= v_cnt
  - video_on <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync <= SYNC_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else ~SYNC_POL
  - vsync <= SYNC_POL when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else ~SYNC_POL
  - line_start <= adv && h_cnt==0
  - frame_start <= adv && h_cnt==0 && v_cnt==0
- Consumer contract: coordinates and video_on are stable for CLK_DIV clks. The consumer samples them on the cycle pix_tick is high.
- Reset (asserted, async, any time including mid-frame):
  - div_cnt, h_cnt, v_cnt = 0
  - pix_tick, line_start, frame_start, video_on = 0
  - x, y = 0
  - hsync, vsync = ~SYNC_POL (inactive)
- After release: the first clk edge loads video_on=1, x=0, y=0. pix_tick first rises on the CLK_DIV-th edge after release.
- CLK_DIV==1: pix_tick is constant 1 from the first edge after release.
- No other inputs. Counters never leave their ranges. There are no simultaneous-event cases beyond the h/v wrap on the same edge.

Decomposition:
- Package vga_pkg:
  - coord_t (logic [COORD_W-1:0])
  - Default 640x480 timing constants
  - H_TOTAL/V_TOTAL computation
  - Sync start/end constants, shared with the colour stage and the top
- Sub-module vga_pix_div: CLK_DIV counter producing adv. It is reusable for other pixel-rate logic.

Test Plan:
1. Hold reset low, then release → hsync=1, vsync=1, video_on=0, x=0, y=0 while reset is low. After edge 1: video_on=1, x=0, y=0. First pix_tick high after edge 4.
2. Free run, 100 clks → pix_tick period exactly 4 clks, 1 clk wide. x increments by 1 on the edge following each pix_tick. No pix_tick gaps.
3. Run one line → hsync low exactly while x=656..751 (96 ticks, 384 clks). Line length 800 ticks = 3200 clks. video_on=0 for x=640..799.
4. Line wrap → after x=799, x=0 and y increments by 1 on the same edge. line_start pulses once per line at x=0.
5. Run 2 full frames → vsync low only for y=490..491 (6400 clks). Frame = 525 lines = 1,680,000 clks. frame_start exactly once per frame at x=0, y=0. y wraps 524→0.
6. Assert reset mid-frame (x=300, y=10, between edges) → all outputs take reset values immediately, without waiting for clk. After release, timing restarts from x=0, y=0, identical to scenario 1.
